pac_counter_updater: RTL and testbench
======================================

// Module: pac_counter_updater
// PURPOSE
//  Consumer (pop side) of the page-access request FIFO. Drains one request per cycle whenever
//  the FIFO is non-empty and extracts the page index from the request address. It then does a
//  saturating increment of that page's access counter in an internal counter array.
//  Provides a registered readout port, a full-array clear sweep, and aggregate statistics.
// PARAMETERS
//  WIDTH        640   request word width; must match the FIFO WIDTH
//  ADDR_LSB     0     bit position of request byte address bit 0 inside fifo_data
//  PAGE_SHIFT   12    log2 page size; page index starts at fifo_data[ADDR_LSB+PAGE_SHIFT]
//  NUM_COUNTERS 1024  number of page counters; power of two, >=2; IDX_W = $clog2(NUM_COUNTERS)
//  CNT_WIDTH    16    width of each page counter
// PORTS
//  clk          in   1          single clock, all state on posedge
//  reset        in   1          asynchronous, active-high reset
//  fifo_empty   in   1          FIFO empty status
//  fifo_data    in   WIDTH      FIFO head word (show-ahead, valid when !fifo_empty)
//  fifo_pop     out  1          pop strobe to FIFO; head consumed at this posedge
//  clear_req    in   1          single-cycle pulse: zero all counters and statistics
//  busy         out  1          high while the clear sweep runs
//  rd_en        in   1          counter readout request
//  rd_idx       in   IDX_W      counter index to read
//  rd_valid     out  1          rd_data valid (1 cycle after rd_en)
//  rd_data      out  CNT_WIDTH  counter value
//  total_count  out  32         number of requests popped since last clear (wraps mod 2^32)
//  sat_flag     out  1          sticky: some counter was incremented while already saturated
// BEHAVIOUR
//  Reset (async assert, sync-release use)
//   - All outputs go to 0; state = CLEAR; sweep_idx = 0; stage-1 valid v1 = 0.
//   - Reset mid-operation discards any in-flight update and restarts the sweep from index 0.
//  FSM: CLEAR -> RUN -> (clear_req) -> CLEAR
//   - CLEAR
//     - busy = 1; fifo_pop = 0.
//     - Writes counter[sweep_idx] = 0 and increments sweep_idx each cycle.
//     - After writing index NUM_COUNTERS-1, moves to RUN. Sweep takes exactly NUM_COUNTERS cycles.
//   - RUN
//     - busy = 0; fifo_pop = !fifo_empty && !clear_req (combinational).
//   - clear_req in RUN: no pop that cycle; next state is CLEAR.
//     - Entering CLEAR drops the in-flight stage-1 update.
//     - Entering CLEAR zeroes total_count and sat_flag.
//   - clear_req in CLEAR: ignored.
//  Update pipeline
//   - Pop edge: v1 <= 1; idx1 <= fifo_data[ADDR_LSB+PAGE_SHIFT +: IDX_W]
//     (page index modulo NUM_COUNTERS); total_count += 1.
//   - Next edge (if v1): counter[idx1] <= (counter[idx1] == all-ones) ? all-ones : counter[idx1] + 1.
//     - If already all-ones, sat_flag <= 1.
//   - Throughput: one request per cycle.
//   - Back-to-back pops to the same index each increment; no updates are lost.
//  Readout
//   - rd_valid <= rd_en on every edge.
//   - rd_data <= counter[rd_idx] (pre-write value, i.e. the array at that edge); 0 while busy.
//   - Latency pop -> visible: a pop at cycle t is returned by rd_en at cycle t+2 (data at t+3).
//  FIFO empty: no pop, v1 <= 0, counters unchanged.
//  Width rules
//   - Counters never wrap.
//   - total_count wraps from 2^32-1 to 0 without setting any flag.
// TESTING
//  1. Reset, idle: busy=1 for exactly NUM_COUNTERS cycles, fifo_pop=0 during the sweep.
//     Then rd_idx 0..1023 -> all 0.
//  2. Push 3 requests with addr 0x3000 (idx 3): fifo_pop high 3 consecutive cycles.
//     Then rd_idx=3 -> 3; total_count=3; rd_idx=4 -> 0.
//  3. Alias: addr 0x5000 and 0x405000 (both idx 5, NUM_COUNTERS=1024) -> counter[5]=2.
//  4. CNT_WIDTH=4: 17 requests to idx 7 -> counter[7]=15; sat_flag=1 after the 16th update.
//  5. clear_req while the FIFO holds 4 entries: no pop in the clear cycle, busy=1 next cycle.
//     total_count=0, sat_flag=0; the 4 entries are counted after the sweep (total_count=4).
//  6. Async reset mid-stream during a pop: outputs 0 immediately; the in-flight update is lost.
//     The sweep restarts from index 0.

Source files
------------

// File: rtl/pac_counter_updater.sv
// Pop-side consumer of the page-access FIFO: saturating per-page access counters,
// a registered readout port, a full-array clear sweep and aggregate statistics.
module pac_counter_updater #(
  parameter int WIDTH        = 640,
  parameter int ADDR_LSB     = 0,
  parameter int PAGE_SHIFT   = 12,
  parameter int NUM_COUNTERS = 1024,
  parameter int CNT_WIDTH    = 16,
  parameter int IDX_W        = $clog2(NUM_COUNTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_pop,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [31:0]          total_count,
  output logic                 sat_flag
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      sweep_idx_q, sweep_idx_d;
  logic                  v1_q, v1_d;
  logic [IDX_W-1:0]      idx1_q, idx1_d;
  logic [31:0]           total_q, total_d;
  logic                  sat_q, sat_d;
  logic                  rd_valid_q;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [CNT_WIDTH-1:0]  cnt_mem [NUM_COUNTERS];
  logic                  we;
  logic [IDX_W-1:0]      waddr;
  logic [CNT_WIDTH-1:0]  wdata;
  logic [CNT_WIDTH-1:0]  cur;
  logic                  pop;
  logic                  unused_data;

  // Only the page-index slice of the request word is meaningful here.
  assign unused_data = ^fifo_data;
  assign cur         = cnt_mem[idx1_q];

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    v1_d        = 1'b0;
    idx1_d      = idx1_q;
    total_d     = total_q;
    sat_d       = sat_q;
    we          = 1'b0;
    waddr       = sweep_idx_q;
    wdata       = '0;
    pop         = 1'b0;
    case (state_q)
      S_CLEAR: begin
        we          = 1'b1;
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == LAST_IDX) state_d = S_RUN;
      end
      default: begin
        if (clear_req) begin
          // The stage-1 update is dropped; the sweep zeroes its target anyway.
          state_d     = S_CLEAR;
          sweep_idx_d = '0;
          total_d     = '0;
          sat_d       = 1'b0;
        end else begin
          if (v1_q) begin
            we    = 1'b1;
            waddr = idx1_q;
            wdata = (cur == CNT_MAX) ? CNT_MAX : cur + 1'b1;
            if (cur == CNT_MAX) sat_d = 1'b1;
          end
          if (!fifo_empty) begin
            pop     = 1'b1;
            v1_d    = 1'b1;
            idx1_d  = fifo_data[ADDR_LSB+PAGE_SHIFT +: IDX_W];
            total_d = total_q + 32'd1;
          end
        end
      end
    endcase
    rd_data_d = (state_q == S_CLEAR) ? '0 : cnt_mem[rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      sweep_idx_q <= '0;
      v1_q        <= 1'b0;
      idx1_q      <= '0;
      total_q     <= '0;
      sat_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      v1_q        <= v1_d;
      idx1_q      <= idx1_d;
      total_q     <= total_d;
      sat_q       <= sat_d;
      rd_valid_q  <= rd_en;
      rd_data_q   <= rd_data_d;
    end
  end

  // Counter array carries no reset; the sweep after reset initialises it.
  always_ff @(posedge clk) begin
    if (we) cnt_mem[waddr] <= wdata;
  end

  assign fifo_pop    = pop;
  assign busy        = (state_q == S_CLEAR) && !reset;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign total_count = total_q;
  assign sat_flag    = sat_q;

endmodule

// File: tb/tb_pac_counter_updater.sv
// Directed bench for pac_counter_updater with a small show-ahead FIFO model (CNT_WIDTH=4).
module tb_pac_counter_updater;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         fifo_empty, fifo_pop, busy, rd_valid, sat_flag;
  logic         clear_req = 1'b0;
  logic         rd_en = 1'b0;
  logic [9:0]   rd_idx = '0;
  logic [3:0]   rd_data;
  logic [31:0]  total_count;
  logic [639:0] fifo_data;

  int          chk = 0;
  int          pass = 0;
  logic [31:0] fmem [64];
  int          head = 0;
  int          tail = 0;

  pac_counter_updater #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .clear_req(clear_req), .busy(busy), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .total_count(total_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);
  assign fifo_data  = {608'b0, fmem[head[5:0]]};
  always @(posedge clk) if (fifo_pop) head <= head + 1;

  task automatic push(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[tail[5:0]] = a;
      tail++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, output logic [3:0] v, output logic vv);
    @(posedge clk); #1;
    rd_en  = 1'b1;
    rd_idx = idx[9:0];
    @(posedge clk); #1;
    rd_en  = 1'b0;
    @(negedge clk);
    v  = rd_data;
    vv = rd_valid;
  endtask

  // Caller sits on a negedge; counts consecutive busy cycles from there.
  task automatic sweep_len(output int n, output logic popped);
    n = 0;
    popped = 1'b0;
    while (busy && n < 2000) begin
      n++;
      if (fifo_pop) popped = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n; logic p; logic [3:0] v; logic vv; logic [3:0] exp;
    push(32'h9000, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk++; if ({busy, fifo_pop, rd_valid, sat_flag, total_count, rd_data} !== '0)
      $display("FAIL reset_outs: got busy=%b pop=%b rv=%b sat=%b tot=%0d rd=%0d want all 0",
               busy, fifo_pop, rd_valid, sat_flag, total_count, rd_data); else pass++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    sweep_len(n, p);
    chk++; if (n !== 1024) $display("FAIL sweep_len: got %0d want 1024", n); else pass++;
    chk++; if (p !== 1'b0) $display("FAIL sweep_pop: got %b want 0", p); else pass++;
    tick(3);
    chk++; if (total_count !== 32'd1) $display("FAIL reset_total: got %0d want 1", total_count); else pass++;
    for (int i = 0; i < 1024; i++) begin
      rd(i, v, vv);
      exp = (i == 9) ? 4'd1 : 4'd0;
      chk++; if (v !== exp) $display("FAIL init_rd[%0d]: got %0d want %0d", i, v, exp); else pass++;
      if (i == 0) begin
        chk++; if (vv !== 1'b1) $display("FAIL rd_valid: got %b want 1", vv); else pass++;
      end
    end
  endtask

  task automatic test_burst;
    logic [4:0] pat; logic [3:0] v; logic vv;
    @(posedge clk); #1;
    push(32'h3000, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[4-k] = fifo_pop;
    end
    chk++; if (pat !== 5'b11100) $display("FAIL burst_pop: got %b want 11100", pat); else pass++;
    rd(3, v, vv);
    chk++; if (v !== 4'd3) $display("FAIL burst_idx3: got %0d want 3", v); else pass++;
    chk++; if (total_count !== 32'd4) $display("FAIL burst_total: got %0d want 4", total_count); else pass++;
    rd(4, v, vv);
    chk++; if (v !== 4'd0) $display("FAIL burst_idx4: got %0d want 0", v); else pass++;
  endtask

  task automatic test_alias;
    logic [3:0] v; logic vv;
    push(32'h5000, 1);
    push(32'h405000, 1);
    tick(4);
    rd(5, v, vv);
    chk++; if (v !== 4'd2) $display("FAIL alias_idx5: got %0d want 2", v); else pass++;
    chk++; if (total_count !== 32'd6) $display("FAIL alias_total: got %0d want 6", total_count); else pass++;
  endtask

  task automatic test_sat;
    logic [3:0] v; logic vv;
    push(32'h7000, 15);
    tick(18);
    rd(7, v, vv);
    chk++; if (v !== 4'd15) $display("FAIL sat_cnt15: got %0d want 15", v); else pass++;
    chk++; if (sat_flag !== 1'b0) $display("FAIL sat_early: got %b want 0", sat_flag); else pass++;
    push(32'h7000, 1);
    tick(4);
    chk++; if (sat_flag !== 1'b1) $display("FAIL sat_16th: got %b want 1", sat_flag); else pass++;
    push(32'h7000, 1);
    tick(4);
    rd(7, v, vv);
    chk++; if (v !== 4'd15) $display("FAIL sat_hold: got %0d want 15", v); else pass++;
    chk++; if (total_count !== 32'd23) $display("FAIL sat_total: got %0d want 23", total_count); else pass++;
  endtask

  task automatic test_clear;
    int n; logic p; logic [3:0] v; logic vv;
    @(posedge clk); #1;
    push(32'h8000, 4);
    clear_req = 1'b1;
    @(negedge clk);
    chk++; if (fifo_pop !== 1'b0) $display("FAIL clr_nopop: got %b want 0", fifo_pop); else pass++;
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    chk++; if (busy !== 1'b1) $display("FAIL clr_busy: got %b want 1", busy); else pass++;
    chk++; if (total_count !== 32'd0) $display("FAIL clr_total: got %0d want 0", total_count); else pass++;
    chk++; if (sat_flag !== 1'b0) $display("FAIL clr_sat: got %b want 0", sat_flag); else pass++;
    sweep_len(n, p);
    chk++; if (n !== 1024) $display("FAIL clr_sweep_len: got %0d want 1024", n); else pass++;
    chk++; if (p !== 1'b0) $display("FAIL clr_sweep_pop: got %b want 0", p); else pass++;
    tick(8);
    chk++; if (total_count !== 32'd4) $display("FAIL clr_after_total: got %0d want 4", total_count); else pass++;
    rd(8, v, vv);
    chk++; if (v !== 4'd4) $display("FAIL clr_idx8: got %0d want 4", v); else pass++;
    rd(7, v, vv);
    chk++; if (v !== 4'd0) $display("FAIL clr_idx7: got %0d want 0", v); else pass++;
  endtask

  task automatic test_reset_mid;
    int n; logic p; logic [3:0] v; logic vv;
    @(posedge clk); #1;
    push(32'h2000, 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk++; if ({busy, fifo_pop, rd_valid, sat_flag, total_count, rd_data} !== '0)
      $display("FAIL mid_reset_outs: got busy=%b pop=%b rv=%b sat=%b tot=%0d rd=%0d want all 0",
               busy, fifo_pop, rd_valid, sat_flag, total_count, rd_data); else pass++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    sweep_len(n, p);
    chk++; if (n !== 1024) $display("FAIL mid_sweep_len: got %0d want 1024", n); else pass++;
    tick(8);
    chk++; if (total_count !== 32'd4) $display("FAIL mid_total: got %0d want 4", total_count); else pass++;
    rd(2, v, vv);
    chk++; if (v !== 4'd4) $display("FAIL mid_idx2: got %0d want 4", v); else pass++;
    rd(3, v, vv);
    chk++; if (v !== 4'd0) $display("FAIL mid_idx3: got %0d want 0", v); else pass++;
  endtask

  initial begin
    test_reset;
    test_burst;
    test_alias;
    test_sat;
    test_clear;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", pass, chk);
    $fatal(1);
  end
endmodule
